// File: rtl/rv_shift_pipe_arbiter_pkg.sv
// rtl/rv_shift_pipe_arbiter_pkg.sv - shared widths and stage-record field offsets for the shift-pipe arbiter
package rv_shift_pipe_arbiter_pkg;

    function automatic int tag_width(input int num_reqs);
        return (num_reqs < 2) ? 1 : $clog2(num_reqs);
    endfunction

    function automatic int cnt_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

    // Stage record layout {valid, tag, data}, for downstream demuxes decoding out_tag
    function automatic int rec_data_lsb();
        return 0;
    endfunction

    function automatic int rec_tag_lsb(input int dataw);
        return dataw;
    endfunction

    function automatic int rec_valid_bit(input int dataw, input int tagw);
        return dataw + tagw;
    endfunction

endpackage

// File: rtl/rv_shift_pipe_arbiter_if.sv
// rtl/rv_shift_pipe_arbiter_if.sv - requester and tail handshake bundle for the shift-pipe arbiter
interface rv_shift_pipe_arbiter_if
    import rv_shift_pipe_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int DEPTH    = 2,
    parameter int TAGW     = tag_width(NUM_REQS)
) ();
    localparam int CNTW = cnt_width(DEPTH);

    logic [NUM_REQS-1:0]       req_valid;
    logic [NUM_REQS*DATAW-1:0] req_data;
    logic [NUM_REQS-1:0]       req_ready;
    logic                      out_valid;
    logic [DATAW-1:0]          out_data;
    logic [TAGW-1:0]           out_tag;
    logic                      out_ready;
    logic [CNTW-1:0]           inflight;

    modport master (
        output req_valid, req_data, out_ready,
        input  req_ready, out_valid, out_data, out_tag, inflight
    );

    modport slave (
        input  req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_tag, inflight
    );
endinterface

// File: rtl/rv_rr_grant.sv
// rtl/rv_rr_grant.sv - round-robin pointer and one-hot winner search for the shift-pipe arbiter
module rv_rr_grant #(
    parameter int NUM_REQS = 4,
    parameter int TAGW     = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] i_req_valid,
    input  logic                i_update,
    input  logic [TAGW-1:0]     i_win_idx,
    output logic [NUM_REQS-1:0] o_winner
);
    localparam logic [TAGW-1:0] LAST_IDX = TAGW'(NUM_REQS - 1);

    logic [TAGW-1:0] r_ptr;
    logic            w_found_hi;
    logic            w_found_lo;
    logic [TAGW-1:0] w_hi_idx;
    logic [TAGW-1:0] w_lo_idx;

    // Lowest valid at or above the pointer wins; otherwise wrap to the lowest valid overall
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        o_winner   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (!w_found_hi && i_req_valid[i] && (i >= int'(r_ptr))) begin
                w_found_hi = 1'b1;
                w_hi_idx   = i[TAGW-1:0];
            end
            if (!w_found_lo && i_req_valid[i]) begin
                w_found_lo = 1'b1;
                w_lo_idx   = i[TAGW-1:0];
            end
        end
        if (w_found_hi) begin
            o_winner[w_hi_idx] = 1'b1;
        end else if (w_found_lo) begin
            o_winner[w_lo_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
        end else if (i_update) begin
            r_ptr <= (i_win_idx == LAST_IDX) ? '0 : i_win_idx + 1'b1;
        end
    end
endmodule

// File: rtl/rv_shift_pipe_arbiter.sv
// rtl/rv_shift_pipe_arbiter.sv - round-robin arbiter feeding a freezable fixed-latency pipe
// Optional stall counter output enabled by RV_SHIFT_PIPE_ARB_PERF_EN.
module rv_shift_pipe_arbiter
    import rv_shift_pipe_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int DATAW    = 32,
    parameter int DEPTH    = 2,
    parameter int TAGW     = tag_width(NUM_REQS)
) (
    input  logic                        clk,
    input  logic                        reset,
    rv_shift_pipe_arbiter_if.slave      bus
`ifdef RV_SHIFT_PIPE_ARB_PERF_EN
    ,
    output logic [31:0]                 o_perf_stall_cycles
`endif
);
    localparam int CNTW = cnt_width(DEPTH);

    logic [NUM_REQS-1:0] w_winner;
    logic [NUM_REQS-1:0] w_ready;
    logic                w_advance;
    logic                w_accept;
    logic                w_fire;
    logic [TAGW-1:0]     w_win_idx;
    logic [DATAW-1:0]    w_sel_data;

    logic                r_valid [DEPTH];
    logic [TAGW-1:0]     r_tag   [DEPTH];
    logic [DATAW-1:0]    r_data  [DEPTH];
    logic [CNTW-1:0]     r_inflight;

    assign w_advance = ~r_valid[DEPTH-1] | bus.out_ready;
    // Held in reset, no requester may see a grant
    assign w_ready   = (w_advance && reset) ? w_winner : '0;
    assign w_accept  = |w_ready;
    assign w_fire    = r_valid[DEPTH-1] & bus.out_ready;

    rv_rr_grant #(
        .NUM_REQS (NUM_REQS),
        .TAGW     (TAGW)
    ) u_grant (
        .clk         (clk),
        .reset       (reset),
        .i_req_valid (bus.req_valid),
        .i_update    (w_accept),
        .i_win_idx   (w_win_idx),
        .o_winner    (w_winner)
    );

    always_comb begin
        w_win_idx  = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (w_winner[i]) begin
                w_win_idx  = i[TAGW-1:0];
                w_sel_data = bus.req_data[i*DATAW +: DATAW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int s = 0; s < DEPTH; s++) begin
                r_valid[s] <= 1'b0;
            end
        end else if (w_advance) begin
            r_valid[0] <= w_accept;
            for (int s = 1; s < DEPTH; s++) begin
                r_valid[s] <= r_valid[s-1];
            end
        end
    end

    // Payload flops carry no reset; they are qualified by the valid chain
    always_ff @(posedge clk) begin
        if (w_advance) begin
            r_tag[0]  <= w_win_idx;
            r_data[0] <= w_sel_data;
            for (int s = 1; s < DEPTH; s++) begin
                r_tag[s]  <= r_tag[s-1];
                r_data[s] <= r_data[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_inflight <= '0;
        end else if (w_accept && !w_fire) begin
            r_inflight <= r_inflight + 1'b1;
        end else if (!w_accept && w_fire) begin
            r_inflight <= r_inflight - 1'b1;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = r_valid[DEPTH-1];
    assign bus.out_tag   = r_tag[DEPTH-1];
    assign bus.out_data  = r_data[DEPTH-1];
    assign bus.inflight  = r_inflight;

`ifdef RV_SHIFT_PIPE_ARB_PERF_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
        end else if ((|bus.req_valid) && !w_advance && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign o_perf_stall_cycles = r_stall_cycles;
`endif
endmodule
